// File: rtl/core_dbg_pkg.sv
// Shared encodings and default timing constants for the core step controller.
// Optional breakpoint support is enabled with CORE_STEP_BREAKPOINT_EN.
package core_dbg_pkg;

  typedef enum logic [1:0] {
    MODE_STEP  = 2'b00,
    MODE_BURST = 2'b01,
    MODE_RUN   = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_BURST,
    S_RUN
  } state_e;

  // 10 ms debounce and 2 Hz free-run at a 50 MHz clk
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_RUN_DIV         = 25000000;

endpackage

// File: rtl/core_step_ctrl_if.sv
// Control/status bundle between the step controller and its environment.
// Breakpoint signals exist only with CORE_STEP_BREAKPOINT_EN.
interface core_step_ctrl_if #(
  parameter int BURST_W = 8,
  parameter int CNT_W   = 32
);
  logic               key_n;
  logic [1:0]         mode;
  logic [BURST_W-1:0] burst_len;
  logic               halt_req;
  logic               core_ce;
  logic               busy;
  logic               key_pressed;
  logic [CNT_W-1:0]   cycle_count;
`ifdef CORE_STEP_BREAKPOINT_EN
  logic [31:0]        pc_now;
  logic [31:0]        bp_addr;
  logic               bp_enable;
  logic               bp_hit;

  modport master (
    output key_n, mode, burst_len, halt_req,
    output pc_now, bp_addr, bp_enable,
    input  core_ce, busy, key_pressed, cycle_count,
    input  bp_hit
  );

  modport slave (
    input  key_n, mode, burst_len, halt_req,
    input  pc_now, bp_addr, bp_enable,
    output core_ce, busy, key_pressed, cycle_count,
    output bp_hit
  );
`else
  modport master (
    output key_n, mode, burst_len, halt_req,
    input  core_ce, busy, key_pressed, cycle_count
  );

  modport slave (
    input  key_n, mode, burst_len, halt_req,
    output core_ce, busy, key_pressed, cycle_count
  );
`endif
endinterface

// File: rtl/key_debounce.sv
// Pushbutton synchronizer, stable-time debounce and registered press pulse.
module key_debounce
  import core_dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_pressed,
  output logic key_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      key_level   <= 1'b1;
      level_d     <= 1'b1;
      cnt         <= '0;
      key_pressed <= 1'b0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      level_d     <= key_level;
      key_pressed <= level_d & ~key_level;
      if (sync2 == key_level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        key_level <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_step_ctrl.sv
// Core clock-enable generator: single step, fixed burst and slow free-run.
// Define CORE_STEP_BREAKPOINT_EN for the PC breakpoint (bp_* signals).
module core_step_ctrl
  import core_dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RUN_DIV         = DEF_RUN_DIV,
  parameter int BURST_W         = 8,
  parameter int CNT_W           = 32
) (
  input logic            clk,
  input logic            rst,
  core_step_ctrl_if.slave bus
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  state_e             state;
  state_e             state_nxt;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] remaining_nxt;
  logic [DW-1:0]      div;
  logic [DW-1:0]      div_nxt;
  logic [CNT_W-1:0]   cycle_count;
  logic               busy;
  logic               ce_raw;
  logic               core_ce;
  logic               key_pressed;
  logic               level_unused;
  logic               bp_stop;
  logic               bp_block;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk        (clk),
    .rst        (rst),
    .key_n      (bus.key_n),
    .key_pressed(key_pressed),
    .key_level  (level_unused)
  );

`ifdef CORE_STEP_BREAKPOINT_EN
  logic bp_hit;
  logic bp_skip;
  logic bp_clear;

  // bp_skip lets the step after a cleared hit run past the same PC
  assign bp_stop  = ce_raw & ~bus.halt_req & bus.bp_enable & ~bp_skip
                  & (bus.pc_now == bus.bp_addr);
  assign bp_clear = bp_hit & key_pressed;
  assign bp_block = bp_hit;
  assign bus.bp_hit = bp_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_hit  <= 1'b0;
      bp_skip <= 1'b0;
    end else begin
      if (bp_stop) bp_hit <= 1'b1;
      else if (bp_clear) bp_hit <= 1'b0;
      if (bp_clear) bp_skip <= 1'b1;
      else if (core_ce) bp_skip <= 1'b0;
    end
  end
`else
  assign bp_stop  = 1'b0;
  assign bp_block = 1'b0;
`endif

  always_comb begin
    ce_raw = (state == S_PULSE) | (state == S_BURST)
           | ((state == S_RUN) & (div == DIV_LAST));
    core_ce = ce_raw & ~bus.halt_req & ~bp_stop;
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    div_nxt       = div;
    if (bus.halt_req || bp_stop) begin
      state_nxt     = S_IDLE;
      remaining_nxt = '0;
      div_nxt       = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!bp_block) begin
            unique case (1'b1)
              bus.mode == MODE_RUN: begin
                state_nxt = S_RUN;
                div_nxt   = '0;
              end
              key_pressed && bus.mode == MODE_STEP:
                state_nxt = S_PULSE;
              key_pressed && bus.mode == MODE_BURST
                && bus.burst_len != '0: begin
                state_nxt     = S_BURST;
                remaining_nxt = bus.burst_len;
              end
              default: ;
            endcase
          end
        end
        S_PULSE: state_nxt = S_IDLE;
        S_BURST: begin
          if (remaining == BURST_W'(1)) begin
            state_nxt     = S_IDLE;
            remaining_nxt = '0;
          end else begin
            remaining_nxt = remaining - 1'b1;
          end
        end
        S_RUN: begin
          if (bus.mode != MODE_RUN) begin
            state_nxt = S_IDLE;
            div_nxt   = '0;
          end else if (div == DIV_LAST) begin
            div_nxt = '0;
          end else begin
            div_nxt = div + 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      remaining   <= '0;
      div         <= '0;
      busy        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      div       <= div_nxt;
      busy      <= (state_nxt != S_IDLE);
      if (core_ce) cycle_count <= cycle_count + 1'b1;
    end
  end

  assign bus.core_ce     = core_ce;
  assign bus.busy        = busy;
  assign bus.key_pressed = key_pressed;
  assign bus.cycle_count = cycle_count;

endmodule
